flag_unit: RTL and testbench

- Producer side of the {N,V,Z} flag register that the branch resolver consumes.
- Computes next flags from the EX-stage ALU result and holds them in a register. Only opcode classes that write flags update it.
- Tracks in-flight flag writers between ID and EX so the branch stage knows when the flags are stale.
- Sits at the EX/MEM boundary. Outputs go straight to the branch-condition logic in ID.

---
 rtl/flag_pkg.sv | 27 ++
 rtl/flag_calc.sv | 37 +++
 rtl/flag_unit.sv | 133 +++++++++++++
 tb/tb_flag_unit.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flag_pkg.sv
// Shared definitions for the {N,V,Z} flag producer: opcode classes,
// flag bit positions and the flag vector width.
package flag_pkg;

  // Width of the packed {N,V,Z} flag vector.
  localparam int FLAG_W = 3;

  // Bit positions inside the packed flag vector.
  localparam int N_IDX = 2;
  localparam int V_IDX = 1;
  localparam int Z_IDX = 0;

  // Flag-writing class of the instruction in EX. Code 3 is reserved and
  // behaves exactly like NONE.
  typedef enum logic [1:0] {
    FLAG_OP_NONE   = 2'd0,
    FLAG_OP_ALL    = 2'd1,
    FLAG_OP_Z_ONLY = 2'd2,
    FLAG_OP_RSVD   = 2'd3
  } flag_op_e;

  // True for the opcode classes that write at least one flag bit.
  function automatic logic flag_op_writes(input flag_op_e op);
    return (op == FLAG_OP_ALL) || (op == FLAG_OP_Z_ONLY);
  endfunction

endpackage

// File: rtl/flag_calc.sv
// Combinational next-flag calculation. Produces the merged {N,V,Z} value
// that the flag register would take if the EX instruction writes flags:
// ALL replaces every bit, Z_ONLY replaces Z only, NONE/reserved keeps the
// current value.
module flag_calc
  import flag_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] i_result,
  input  logic              i_ovfl,
  input  flag_op_e          i_op,
  input  logic [FLAG_W-1:0] i_cur,
  output logic [FLAG_W-1:0] o_next
);

  logic [FLAG_W-1:0] w_raw;

  // Raw flags derived from the ALU result, before merging with i_cur.
  always_comb begin
    w_raw        = '0;
    w_raw[Z_IDX] = (i_result == '0);
    w_raw[N_IDX] = i_result[DATA_W-1];
    w_raw[V_IDX] = i_ovfl;
  end

  // Merge raw flags into the current value according to the opcode class.
  always_comb begin
    o_next = i_cur;
    case (i_op)
      FLAG_OP_ALL:    o_next = w_raw;
      FLAG_OP_Z_ONLY: o_next[Z_IDX] = w_raw[Z_IDX];
      default:        o_next = i_cur;
    endcase
  end

endmodule

// File: rtl/flag_unit.sv
// Flag register, in-flight flag-writer counter and branch forwarding mux.
// Sits at the EX/MEM boundary; outputs feed the branch condition logic in ID.
//
// Optional feature macro: FLAG_FWD_EN
//   defined   : flag_fwd carries the merged next flags in the cycle the EX
//               instruction fires, and that instruction is not counted as
//               pending.
//   undefined : flag_fwd is the registered value and the firing writer still
//               counts as pending (branches wait one extra cycle).
//
// Handshake: there is no valid/ready pair here. ex_valid qualifies the EX
// instruction, stall freezes every piece of state (no update, no bypass),
// and flush clears the pending count while still letting the EX instruction
// of that cycle write the flags.
module flag_unit
  import flag_pkg::*;
#(
  parameter int DATA_W       = 16,
  parameter int MAX_INFLIGHT = 3,
  localparam int CNT_W       = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic [1:0]        ex_flag_op,
  input  logic [DATA_W-1:0] ex_result,
  input  logic              ex_ovfl,
  input  logic              id_issue_flagop,
  input  logic              stall,
  input  logic              flush,
  output logic [FLAG_W-1:0] flag_reg,
  output logic [FLAG_W-1:0] flag_fwd,
  output logic              flags_pending,
  output logic [CNT_W-1:0]  inflight_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_INFLIGHT);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [FLAG_W-1:0] r_flags;
  logic [CNT_W-1:0]  r_cnt;

  flag_op_e          w_op;
  logic              w_ex_fire;
  logic              w_inc;
  logic              w_dec;
  logic [FLAG_W-1:0] w_next_flags;
  logic [CNT_W-1:0]  w_cnt_next;
  logic [CNT_W-1:0]  w_dec_ext;

  assign w_op      = flag_op_e'(ex_flag_op);
  assign w_ex_fire = ex_valid & ~stall & flag_op_writes(w_op);
  assign w_inc     = id_issue_flagop & ~stall & ~flush;
  assign w_dec     = w_ex_fire;
  assign w_dec_ext = {{(CNT_W-1){1'b0}}, w_dec};

  flag_calc #(
    .DATA_W (DATA_W)
  ) u_flag_calc (
    .i_result (ex_result),
    .i_ovfl   (ex_ovfl),
    .i_op     (w_op),
    .i_cur    (r_flags),
    .o_next   (w_next_flags)
  );

  // Flag register: loads the merged value only when an EX writer fires.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_flags <= '0;
    end else if (w_ex_fire) begin
      r_flags <= w_next_flags;
    end
  end

  // Next pending count: flush clears, otherwise saturating +1/-1 with a
  // simultaneous issue and retire cancelling out.
  always_comb begin
    w_cnt_next = r_cnt;
    if (flush) begin
      w_cnt_next = CNT_ZERO;
    end else begin
      case ({w_inc, w_dec})
        2'b10: w_cnt_next = (r_cnt == CNT_MAX)  ? r_cnt : r_cnt + CNT_ONE;
        2'b01: w_cnt_next = (r_cnt == CNT_ZERO) ? r_cnt : r_cnt - CNT_ONE;
        default: w_cnt_next = r_cnt;
      endcase
    end
  end

  // Pending counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_next;
    end
  end

`ifdef FLAG_FWD_EN
  // Bypass the merged flags in the firing cycle; the firing writer is
  // already visible, so only older writers count as pending. The compare
  // form also keeps the clamped underflow case (count 0, retire) at 0.
  always_comb begin
    flag_fwd      = w_ex_fire ? w_next_flags : r_flags;
    flags_pending = (r_cnt > w_dec_ext);
  end
`else
  // No bypass: branches see only the registered flags, so the writer that
  // is firing right now is still pending until its result lands.
  always_comb begin
    flag_fwd      = r_flags;
    flags_pending = (r_cnt != CNT_ZERO) | (w_dec_ext != CNT_ZERO & 1'b0);
  end
`endif

  assign flag_reg     = r_flags;
  assign inflight_cnt = r_cnt;

`ifndef SYNTHESIS
  // Simulation-only boundary monitors for the pending counter.
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(w_inc && !w_dec && r_cnt == CNT_MAX))
        else $warning("flag_unit: in-flight flag writers exceed MAX_INFLIGHT, count saturated");
      assert (!(w_dec && !w_inc && !flush && r_cnt == CNT_ZERO))
        else $warning("flag_unit: flag writer retired with no pending count, count clamped at 0");
    end
  end
`endif

endmodule

// File: tb/tb_flag_unit.sv
// Directed testbench for flag_unit. Each task drives one scenario and checks
// results inline against hand-computed values. Expectations that depend on
// FLAG_FWD_EN are selected through the FWD constant.
module tb_flag_unit;

  localparam int DATA_W       = 16;
  localparam int MAX_INFLIGHT = 3;
  localparam int CNT_W        = $clog2(MAX_INFLIGHT + 1);

`ifdef FLAG_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  localparam logic [1:0] OP_NONE = 2'd0;
  localparam logic [1:0] OP_ALL  = 2'd1;
  localparam logic [1:0] OP_Z    = 2'd2;
  localparam logic [1:0] OP_RSVD = 2'd3;

  // Clock and reset block
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              ex_valid;
  logic [1:0]        ex_flag_op;
  logic [DATA_W-1:0] ex_result;
  logic              ex_ovfl;
  logic              id_issue_flagop;
  logic              stall;
  logic              flush;
  logic [2:0]        flag_reg;
  logic [2:0]        flag_fwd;
  logic              flags_pending;
  logic [CNT_W-1:0]  inflight_cnt;

  int errors = 0;
  int checks = 0;

  flag_unit #(
    .DATA_W       (DATA_W),
    .MAX_INFLIGHT (MAX_INFLIGHT)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .ex_valid        (ex_valid),
    .ex_flag_op      (ex_flag_op),
    .ex_result       (ex_result),
    .ex_ovfl         (ex_ovfl),
    .id_issue_flagop (id_issue_flagop),
    .stall           (stall),
    .flush           (flush),
    .flag_reg        (flag_reg),
    .flag_fwd        (flag_fwd),
    .flags_pending   (flags_pending),
    .inflight_cnt    (inflight_cnt)
  );

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ex_valid        = 1'b0;
    ex_flag_op      = OP_NONE;
    ex_result       = '0;
    ex_ovfl         = 1'b0;
    id_issue_flagop = 1'b0;
    stall           = 1'b0;
    flush           = 1'b0;
    #1;
  endtask

  task automatic drive_ex(input logic [1:0] op, input logic [DATA_W-1:0] res,
                          input logic ovfl);
    ex_valid   = 1'b1;
    ex_flag_op = op;
    ex_result  = res;
    ex_ovfl    = ovfl;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (flag_reg !== 3'b000) begin errors++; $display("FAIL reset_flag_reg: got %b expected %b", flag_reg, 3'b000); end
    checks++;
    if (flag_fwd !== 3'b000) begin errors++; $display("FAIL reset_flag_fwd: got %b expected %b", flag_fwd, 3'b000); end
    checks++;
    if (inflight_cnt !== 2'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", inflight_cnt); end
    checks++;
    if (flags_pending !== 1'b0) begin errors++; $display("FAIL reset_pending: got %b expected 0", flags_pending); end
  endtask

  task automatic test_all_fire();
    drive_ex(OP_ALL, 16'h8000, 1'b1);
    checks++;
    if (flag_fwd !== (FWD ? 3'b110 : 3'b000)) begin errors++; $display("FAIL all_fwd_same_cycle: got %b expected %b", flag_fwd, (FWD ? 3'b110 : 3'b000)); end
    checks++;
    if (flag_reg !== 3'b000) begin errors++; $display("FAIL all_reg_before_edge: got %b expected %b", flag_reg, 3'b000); end
    tick();
    idle();
    checks++;
    if (flag_reg !== 3'b110) begin errors++; $display("FAIL all_reg_next: got %b expected %b", flag_reg, 3'b110); end
    checks++;
    if (flag_fwd !== 3'b110) begin errors++; $display("FAIL all_fwd_idle: got %b expected %b", flag_fwd, 3'b110); end
    checks++;
    if (inflight_cnt !== 2'd0) begin errors++; $display("FAIL all_cnt_clamp: got %0d expected 0", inflight_cnt); end
  endtask

  task automatic test_z_only();
    drive_ex(OP_Z, 16'h0000, 1'b0);
    checks++;
    if (flag_fwd !== (FWD ? 3'b111 : 3'b110)) begin errors++; $display("FAIL zonly_fwd: got %b expected %b", flag_fwd, (FWD ? 3'b111 : 3'b110)); end
    tick();
    idle();
    checks++;
    if (flag_reg !== 3'b111) begin errors++; $display("FAIL zonly_reg: got %b expected %b", flag_reg, 3'b111); end
    // Z_ONLY with a nonzero result clears Z but keeps N and V.
    drive_ex(OP_Z, 16'h0004, 1'b0);
    tick();
    idle();
    checks++;
    if (flag_reg !== 3'b110) begin errors++; $display("FAIL zonly_clear_z: got %b expected %b", flag_reg, 3'b110); end
  endtask

  task automatic test_no_write();
    drive_ex(OP_NONE, 16'h0000, 1'b0);
    tick();
    checks++;
    if (flag_reg !== 3'b110) begin errors++; $display("FAIL none_hold: got %b expected %b", flag_reg, 3'b110); end
    drive_ex(OP_RSVD, 16'h0000, 1'b0);
    checks++;
    if (flag_fwd !== 3'b110) begin errors++; $display("FAIL rsvd_fwd: got %b expected %b", flag_fwd, 3'b110); end
    tick();
    idle();
    checks++;
    if (flag_reg !== 3'b110) begin errors++; $display("FAIL rsvd_hold: got %b expected %b", flag_reg, 3'b110); end
    // Valid low with ALL must not write either.
    ex_flag_op = OP_ALL;
    ex_result  = 16'h0000;
    tick();
    idle();
    checks++;
    if (flag_reg !== 3'b110) begin errors++; $display("FAIL invalid_hold: got %b expected %b", flag_reg, 3'b110); end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    id_issue_flagop = 1'b1;
    drive_ex(OP_ALL, 16'h0000, 1'b0);
    checks++;
    if (flag_fwd !== 3'b110) begin errors++; $display("FAIL stall_no_bypass: got %b expected %b", flag_fwd, 3'b110); end
    tick();
    checks++;
    if (flag_reg !== 3'b110) begin errors++; $display("FAIL stall_reg_hold: got %b expected %b", flag_reg, 3'b110); end
    checks++;
    if (inflight_cnt !== 2'd0) begin errors++; $display("FAIL stall_cnt_hold: got %0d expected 0", inflight_cnt); end
    idle();
  endtask

  task automatic test_saturate();
    logic [CNT_W-1:0] exp_cnt [4];
    exp_cnt[0] = 2'd1;
    exp_cnt[1] = 2'd2;
    exp_cnt[2] = 2'd3;
    exp_cnt[3] = 2'd3;
    id_issue_flagop = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (inflight_cnt !== exp_cnt[i]) begin errors++; $display("FAIL sat_cnt_%0d: got %0d expected %0d", i, inflight_cnt, exp_cnt[i]); end
      checks++;
      if (flags_pending !== 1'b1) begin errors++; $display("FAIL sat_pending_%0d: got %b expected 1", i, flags_pending); end
    end
    idle();
    // One retire brings the count to 2 and loads 3'b000.
    drive_ex(OP_ALL, 16'h0001, 1'b0);
    tick();
    idle();
    checks++;
    if (inflight_cnt !== 2'd2) begin errors++; $display("FAIL sat_retire_cnt: got %0d expected 2", inflight_cnt); end
    checks++;
    if (flag_reg !== 3'b000) begin errors++; $display("FAIL sat_retire_reg: got %b expected %b", flag_reg, 3'b000); end
  endtask

  task automatic test_back_to_back();
    id_issue_flagop = 1'b1;
    drive_ex(OP_ALL, 16'h0001, 1'b0);
    checks++;
    if (flags_pending !== 1'b1) begin errors++; $display("FAIL b2b_pending: got %b expected 1", flags_pending); end
    tick();
    checks++;
    if (inflight_cnt !== 2'd2) begin errors++; $display("FAIL b2b_cnt: got %0d expected 2", inflight_cnt); end
    // Retire with no issue: 2 -> 1, flags become N only.
    id_issue_flagop = 1'b0;
    drive_ex(OP_ALL, 16'h8000, 1'b0);
    tick();
    idle();
    checks++;
    if (inflight_cnt !== 2'd1) begin errors++; $display("FAIL b2b_cnt_dec: got %0d expected 1", inflight_cnt); end
    checks++;
    if (flag_reg !== 3'b100) begin errors++; $display("FAIL b2b_reg: got %b expected %b", flag_reg, 3'b100); end
  endtask

  task automatic test_last_writer();
    drive_ex(OP_ALL, 16'h0001, 1'b0);
    checks++;
    if (flags_pending !== (FWD ? 1'b0 : 1'b1)) begin errors++; $display("FAIL last_pending: got %b expected %b", flags_pending, (FWD ? 1'b0 : 1'b1)); end
    checks++;
    if (flag_fwd !== (FWD ? 3'b000 : 3'b100)) begin errors++; $display("FAIL last_fwd: got %b expected %b", flag_fwd, (FWD ? 3'b000 : 3'b100)); end
    tick();
    idle();
    checks++;
    if (inflight_cnt !== 2'd0) begin errors++; $display("FAIL last_cnt: got %0d expected 0", inflight_cnt); end
    checks++;
    if (flags_pending !== 1'b0) begin errors++; $display("FAIL last_pending_after: got %b expected 0", flags_pending); end
    checks++;
    if (flag_reg !== 3'b000) begin errors++; $display("FAIL last_reg: got %b expected %b", flag_reg, 3'b000); end
  endtask

  task automatic test_flush();
    id_issue_flagop = 1'b1;
    tick();
    tick();
    id_issue_flagop = 1'b0;
    #1;
    checks++;
    if (inflight_cnt !== 2'd2) begin errors++; $display("FAIL flush_setup_cnt: got %0d expected 2", inflight_cnt); end
    flush = 1'b1;
    id_issue_flagop = 1'b1;
    drive_ex(OP_ALL, 16'h0000, 1'b0);
    tick();
    idle();
    checks++;
    if (inflight_cnt !== 2'd0) begin errors++; $display("FAIL flush_cnt: got %0d expected 0", inflight_cnt); end
    checks++;
    if (flag_reg !== 3'b001) begin errors++; $display("FAIL flush_reg: got %b expected %b", flag_reg, 3'b001); end
  endtask

  task automatic test_reset_mid();
    id_issue_flagop = 1'b1;
    tick();
    drive_ex(OP_ALL, 16'h8000, 1'b1);
    stall = 1'b1;
    rst   = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    checks++;
    if (flag_reg !== 3'b000) begin errors++; $display("FAIL rst_stall_reg: got %b expected %b", flag_reg, 3'b000); end
    checks++;
    if (inflight_cnt !== 2'd0) begin errors++; $display("FAIL rst_stall_cnt: got %0d expected 0", inflight_cnt); end
    checks++;
    if (flags_pending !== 1'b0) begin errors++; $display("FAIL rst_stall_pending: got %b expected 0", flags_pending); end
    // Reset also beats an unstalled EX fire.
    drive_ex(OP_ALL, 16'h8000, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    checks++;
    if (flag_reg !== 3'b000) begin errors++; $display("FAIL rst_fire_reg: got %b expected %b", flag_reg, 3'b000); end
  endtask

  initial begin
    test_reset();
    test_all_fire();
    test_z_only();
    test_no_write();
    test_stall();
    test_saturate();
    test_back_to_back();
    test_last_writer();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
